mem_bus_arbiter: RTL

//  Shares one single-port memory bus between instruction fetch (IF) and the

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_bus_arbiter_timeout_ctr.sv | 36 +++
 rtl/mem_bus_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IF/MEM memory bus arbiter.
// Holds FSM state codes, write-enable levels and the counter width helper.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_BUSY_IF  = 2'd1,
      ARB_BUSY_MEM = 2'd2,
      ARB_DONE     = 2'd3
   } arb_state_e;

   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   // Bits needed to count from 0 up to limit inclusive.
   function automatic int cnt_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_ctr.sv
// Bus-cycle watchdog, built only when ARB_TIMEOUT_EN is defined.
// Ports: clk, rst (async, active low), i_clear, i_enable, o_expire.
`ifdef ARB_TIMEOUT_EN
module arb_timeout_ctr
   import mem_bus_arbiter_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int W = cnt_width(LIMIT);

   logic [W-1:0] r_cnt;
   logic         w_hit;

   // Terminal count is LIMIT-1: the LIMIT-th busy cycle expires.
   assign w_hit    = (r_cnt == W'(LIMIT - 1));
   assign o_expire = i_enable & w_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && !w_hit) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter, MEM over IF, with stall requests.
// Ports: clk, rst (async low), flush; IF req/addr/rdata/ack;
//   MEM req/we/sel/addr/wdata/rdata/ack; stallreq_if/mem;
//   bus stb/we/sel/addr/wdata/rdata/ack/err.
// Optional watchdog: define ARB_TIMEOUT_EN.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ack,
   input  logic                mem_req,
   input  logic                mem_we,
   input  logic [DATA_W/8-1:0] mem_sel,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_ack,
   output logic                stallreq_if,
   output logic                stallreq_mem,
   output logic                bus_stb,
   output logic                bus_we,
   output logic [DATA_W/8-1:0] bus_sel,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_ack,
   output logic                bus_err
);

   localparam int SEL_W = DATA_W / 8;

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic              r_stb;
   logic              w_stb_nxt;
   logic              r_we;
   logic              w_we_nxt;
   logic [SEL_W-1:0]  r_sel;
   logic [SEL_W-1:0]  w_sel_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] w_wdata_nxt;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] w_if_rdata_nxt;
   logic [DATA_W-1:0] r_mem_rdata;
   logic [DATA_W-1:0] w_mem_rdata_nxt;
   logic              r_if_ack;
   logic              w_if_ack_nxt;
   logic              r_mem_ack;
   logic              w_mem_ack_nxt;
   logic              r_err;
   logic              w_err_nxt;
   logic              r_kill;
   logic              w_kill_nxt;
   logic              w_killed;
   logic              w_grant;
   logic              w_expire;

`ifdef ARB_TIMEOUT_EN
   arb_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_grant),
      .i_enable (r_stb),
      .o_expire (w_expire)
   );
`else
   logic w_unused_cfg;
   assign w_expire     = 1'b0;
   assign w_unused_cfg = w_grant ^ (TIMEOUT_CYCLES != 0);
`endif

   // A flush seen at any point of an IF bus cycle kills its ack.
   assign w_killed = r_kill | flush;

   always_comb begin
      w_state_nxt     = r_state;
      w_stb_nxt       = r_stb;
      w_we_nxt        = r_we;
      w_sel_nxt       = r_sel;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_if_rdata_nxt  = r_if_rdata;
      w_mem_rdata_nxt = r_mem_rdata;
      w_if_ack_nxt    = 1'b0;
      w_mem_ack_nxt   = 1'b0;
      w_err_nxt       = 1'b0;
      w_kill_nxt      = r_kill;
      w_grant         = 1'b0;
      unique case (r_state)
         ARB_IDLE: begin
            if (mem_req) begin
               w_grant     = 1'b1;
               w_stb_nxt   = 1'b1;
               w_we_nxt    = mem_we;
               w_sel_nxt   = mem_sel;
               w_addr_nxt  = mem_addr;
               w_wdata_nxt = mem_wdata;
               w_state_nxt = ARB_BUSY_MEM;
            end else if (if_req && !flush) begin
               w_grant     = 1'b1;
               w_stb_nxt   = 1'b1;
               w_we_nxt    = WRITE_DISABLE;
               w_sel_nxt   = '1;
               w_addr_nxt  = if_addr;
               w_wdata_nxt = '0;
               w_kill_nxt  = 1'b0;
               w_state_nxt = ARB_BUSY_IF;
            end
         end
         ARB_BUSY_IF: begin
            w_kill_nxt = w_killed;
            // Slave ack on the terminal count wins over timeout.
            if (bus_ack || w_expire) begin
               w_stb_nxt   = 1'b0;
               w_err_nxt   = !bus_ack;
               w_state_nxt = ARB_DONE;
               if (!w_killed) begin
                  w_if_ack_nxt   = 1'b1;
                  w_if_rdata_nxt = bus_ack ? bus_rdata : '0;
               end
            end
         end
         ARB_BUSY_MEM: begin
            if (bus_ack || w_expire) begin
               w_stb_nxt     = 1'b0;
               w_err_nxt     = !bus_ack;
               w_mem_ack_nxt = 1'b1;
               w_state_nxt   = ARB_DONE;
               if (!bus_ack) begin
                  w_mem_rdata_nxt = '0;
               end else if (r_we == WRITE_DISABLE) begin
                  w_mem_rdata_nxt = bus_rdata;
               end
            end
         end
         ARB_DONE: begin
            w_state_nxt = ARB_IDLE;
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stb       <= 1'b0;
         r_we        <= WRITE_DISABLE;
         r_sel       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
         r_if_ack    <= 1'b0;
         r_mem_ack   <= 1'b0;
         r_err       <= 1'b0;
         r_kill      <= 1'b0;
      end else begin
         r_stb       <= w_stb_nxt;
         r_we        <= w_we_nxt;
         r_sel       <= w_sel_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_if_rdata  <= w_if_rdata_nxt;
         r_mem_rdata <= w_mem_rdata_nxt;
         r_if_ack    <= w_if_ack_nxt;
         r_mem_ack   <= w_mem_ack_nxt;
         r_err       <= w_err_nxt;
         r_kill      <= w_kill_nxt;
      end
   end

   assign bus_stb      = r_stb;
   assign bus_we       = r_we;
   assign bus_sel      = r_sel;
   assign bus_addr     = r_addr;
   assign bus_wdata    = r_wdata;
   assign bus_err      = r_err;
   assign if_rdata     = r_if_rdata;
   assign if_ack       = r_if_ack;
   assign mem_rdata    = r_mem_rdata;
   assign mem_ack      = r_mem_ack;
   assign stallreq_if  = if_req & ~r_if_ack;
   assign stallreq_mem = mem_req & ~r_mem_ack;

endmodule
